// File: rtl/multi_vote_counter_pkg.sv
// Shared types for the election tally block.
// Poll states and vote reject reasons.
package multi_vote_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    TALLY = 2'd2,
    DONE  = 2'd3
  } poll_state_t;

  localparam logic [1:0] REJ_NONE    = 2'd0;
  localparam logic [1:0] REJ_CLOSED  = 2'd1;
  localparam logic [1:0] REJ_BADCAND = 2'd2;
  localparam logic [1:0] REJ_DUP     = 2'd3;

endpackage

// File: rtl/multi_vote_counter_scan.sv
// Sequential max/tie finder: one candidate per cycle after start.
// done, winner and tie reflect the final element on the last scan cycle.
module vote_tally_scan #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int CAND_W   = $clog2(NUM_CAND)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start_i,
  input  logic [NUM_CAND-1:0][CNT_W-1:0]     cnt_i,
  output logic                               done_o,
  output logic [CAND_W-1:0]                  winner_o,
  output logic                               tie_o
);

  localparam logic [CAND_W-1:0] LAST = CAND_W'(NUM_CAND - 1);

  logic              busy_q;
  logic [CAND_W-1:0] idx_q;
  logic [CNT_W-1:0]  max_q, max_d, cur;
  logic [CAND_W-1:0] win_q, win_d;
  logic              tie_q, tie_d;

  assign cur = cnt_i[idx_q];

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    max_d = max_q;
    win_d = win_q;
    tie_d = tie_q;
    if (idx_q == '0 || cur > max_q) begin
      max_d = cur;
      win_d = idx_q;
      tie_d = 1'b0;
    end else if (cur == max_q) begin
      tie_d = 1'b1;
    end
  end

  assign done_o   = busy_q && (idx_q == LAST);
  assign winner_o = win_d;
  assign tie_o    = tie_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      max_q  <= '0;
      win_q  <= '0;
      tie_q  <= 1'b0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      idx_q  <= '0;
    end else if (busy_q) begin
      max_q <= max_d;
      win_q <= win_d;
      tie_q <= tie_d;
      idx_q <= idx_q + 1'b1;
      if (idx_q == LAST) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_vote_counter.sv
// Election tally: one vote per voter per session, saturating counts,
// sequential winner/tie scan after the poll closes.
module multi_vote_counter
  import multi_vote_pkg::*;
#(
  parameter int NUM_CAND   = 4,
  parameter int CNT_W      = 8,
  parameter int NUM_VOTERS = 16,
  parameter int CAND_W     = $clog2(NUM_CAND),
  parameter int VID_W      = $clog2(NUM_VOTERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        open_poll,
  input  logic                        close_poll,
  input  logic                        vote_valid,
  input  logic [VID_W-1:0]            voter_id,
  input  logic [CAND_W-1:0]           cand_sel,
  output logic                        vote_accept,
  output logic                        vote_reject,
  output logic [1:0]                  reject_code,
  output logic [NUM_CAND*CNT_W-1:0]   votes_flat,
  output logic [CNT_W+CAND_W-1:0]     total_votes,
  output logic                        sat_flag,
  output logic [1:0]                  poll_state,
  output logic                        result_valid,
  output logic [CAND_W-1:0]           winner,
  output logic                        tie
);

  localparam logic [CAND_W:0] NC = (CAND_W + 1)'(NUM_CAND);

  poll_state_t                   state_q;
  logic [NUM_CAND-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W+CAND_W-1:0]       tot_q, tot_d;
  logic [NUM_VOTERS-1:0]         voted_q, voted_d;
  logic                          sat_q, sat_d;
  logic [CAND_W-1:0]             win_q;
  logic                          tie_q;
  logic                          acc_q, rej_q;
  logic [1:0]                    code_q, rej_code;
  logic                          cand_ok, vote_ok, accept;
  logic                          open_go, close_go;
  logic                          scan_done, scan_tie;
  logic [CAND_W-1:0]             scan_win;

  assign open_go  = open_poll && (state_q == IDLE || state_q == DONE);
  assign close_go = close_poll && (state_q == OPEN);
  assign cand_ok  = {1'b0, cand_sel} < NC;

  always_comb begin
    rej_code = REJ_NONE;
    if (state_q != OPEN)       rej_code = REJ_CLOSED;
    else if (!cand_ok)         rej_code = REJ_BADCAND;
    else if (voted_q[voter_id]) rej_code = REJ_DUP;
  end

  assign vote_ok = (rej_code == REJ_NONE);
  assign accept  = vote_valid && vote_ok;

  always_comb begin
    cnt_d   = cnt_q;
    tot_d   = tot_q;
    voted_d = voted_q;
    sat_d   = sat_q;
    if (open_go) begin
      cnt_d   = '0;
      tot_d   = '0;
      voted_d = '0;
      sat_d   = 1'b0;
    end else if (accept) begin
      voted_d[voter_id] = 1'b1;
      if (&cnt_q[cand_sel]) sat_d = 1'b1;
      else cnt_d[cand_sel] = cnt_q[cand_sel] + 1'b1;
      if (!(&tot_q)) tot_d = tot_q + 1'b1;
    end
  end

  vote_tally_scan #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W),
    .CAND_W   (CAND_W)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .start_i  (close_go),
    .cnt_i    (cnt_q),
    .done_o   (scan_done),
    .winner_o (scan_win),
    .tie_o    (scan_tie)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tot_q   <= '0;
      voted_q <= '0;
      sat_q   <= 1'b0;
      win_q   <= '0;
      tie_q   <= 1'b0;
      acc_q   <= 1'b0;
      rej_q   <= 1'b0;
      code_q  <= REJ_NONE;
    end else begin
      acc_q   <= accept;
      rej_q   <= vote_valid && !vote_ok;
      code_q  <= vote_valid ? rej_code : REJ_NONE;
      cnt_q   <= cnt_d;
      tot_q   <= tot_d;
      voted_q <= voted_d;
      sat_q   <= sat_d;
      unique case (state_q)
        IDLE:  if (open_poll) state_q <= OPEN;
        OPEN:  if (close_poll) state_q <= TALLY;
        TALLY: if (scan_done) begin
          state_q <= DONE;
          win_q   <= scan_win;
          tie_q   <= scan_tie;
        end
        DONE:  if (open_poll) state_q <= OPEN;
      endcase
      if (open_go) begin
        win_q <= '0;
        tie_q <= 1'b0;
      end
    end
  end

  assign vote_accept  = acc_q;
  assign vote_reject  = rej_q;
  assign reject_code  = code_q;
  assign votes_flat   = cnt_q;
  assign total_votes  = tot_q;
  assign sat_flag     = sat_q;
  assign poll_state   = state_q;
  assign result_valid = (state_q == DONE);
  assign winner       = win_q;
  assign tie          = tie_q;

endmodule

// File: tb/tb_multi_vote_counter.sv
// Scoreboard bench for multi_vote_counter against a behavioural
// election model; directed scenarios followed by random traffic.
module tb_multi_vote_counter;

  localparam int NC  = 5;
  localparam int CW  = 2;
  localparam int NV  = 16;
  localparam int CAW = $clog2(NC);
  localparam int VW  = $clog2(NV);
  localparam int CMAX = (1 << CW) - 1;
  localparam int TMAX = (1 << (CW + CAW)) - 1;

  logic clk = 1'b0;
  logic reset, open_poll, close_poll, vote_valid;
  logic [VW-1:0]      voter_id;
  logic [CAW-1:0]     cand_sel;
  logic               vote_accept, vote_reject;
  logic [1:0]         reject_code;
  logic [NC*CW-1:0]   votes_flat;
  logic [CW+CAW-1:0]  total_votes;
  logic               sat_flag;
  logic [1:0]         poll_state;
  logic               result_valid;
  logic [CAW-1:0]     winner;
  logic               tie;

  multi_vote_counter #(
    .NUM_CAND(NC), .CNT_W(CW), .NUM_VOTERS(NV)
  ) dut (
    .clk(clk), .reset(reset),
    .open_poll(open_poll), .close_poll(close_poll),
    .vote_valid(vote_valid), .voter_id(voter_id),
    .cand_sel(cand_sel),
    .vote_accept(vote_accept), .vote_reject(vote_reject),
    .reject_code(reject_code), .votes_flat(votes_flat),
    .total_votes(total_votes), .sat_flag(sat_flag),
    .poll_state(poll_state), .result_valid(result_valid),
    .winner(winner), .tie(tie)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       acc;
    int       code;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;

  // Reference election state: 0 idle, 1 open, 2 tally, 3 done.
  int cnt_m[NC];
  bit voted_m[NV];
  int tot_m, st_m, left_m, win_m;
  bit sat_m, tie_m;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void clear_session();
    foreach (cnt_m[i]) cnt_m[i] = 0;
    foreach (voted_m[i]) voted_m[i] = 1'b0;
    tot_m = 0;
    sat_m = 1'b0;
    win_m = 0;
    tie_m = 1'b0;
  endfunction

  function automatic void decide();
    int mx, n;
    mx = 0;
    foreach (cnt_m[i]) if (cnt_m[i] > mx) mx = cnt_m[i];
    n = 0;
    win_m = -1;
    foreach (cnt_m[i]) if (cnt_m[i] == mx) begin
      if (win_m < 0) win_m = i;
      n++;
    end
    tie_m = (n > 1);
  endfunction

  function automatic void model_edge(bit rs, bit op, bit cl, bit vv,
                                     int vid, int cand);
    exp_t e;
    if (rs) begin
      clear_session();
      st_m = 0;
      return;
    end
    if (vv) begin
      if (st_m != 1) e.code = 1;
      else if (cand >= NC) e.code = 2;
      else if (voted_m[vid]) e.code = 3;
      else e.code = 0;
      e.acc = (e.code == 0);
      exp_q.push_back(e);
      if (e.acc) begin
        voted_m[vid] = 1'b1;
        if (cnt_m[cand] == CMAX) sat_m = 1'b1;
        else cnt_m[cand]++;
        if (tot_m < TMAX) tot_m++;
      end
    end
    case (st_m)
      0: if (op) begin clear_session(); st_m = 1; end
      1: if (cl) begin st_m = 2; left_m = NC; end
      2: begin
        left_m--;
        if (left_m == 0) begin st_m = 3; decide(); end
      end
      default: if (op) begin clear_session(); st_m = 1; end
    endcase
  endfunction

  task automatic check_state();
    chk("poll_state", int'(poll_state), st_m);
    chk("result_valid", int'(result_valid), int'(st_m == 3));
    chk("winner", int'(winner), win_m);
    chk("tie", int'(tie), int'(tie_m));
    chk("total_votes", int'(total_votes), tot_m);
    chk("sat_flag", int'(sat_flag), int'(sat_m));
    for (int i = 0; i < NC; i++)
      chk($sformatf("votes[%0d]", i), int'(votes_flat[i*CW +: CW]), cnt_m[i]);
  endtask

  task automatic step(bit rs, bit op, bit cl, bit vv, int vid, int cand);
    reset      = rs;
    open_poll  = op;
    close_poll = cl;
    vote_valid = vv;
    voter_id   = VW'(vid);
    cand_sel   = CAW'(cand);
    model_edge(rs, op, cl, vv, vid, cand);
    @(posedge clk);
    #1;
    reset = 0; open_poll = 0; close_poll = 0; vote_valid = 0;
    check_state();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic vote(int vid, int cand);
    step(0, 0, 0, 1, vid, cand);
  endtask

  // Monitor: every accept/reject pulse is matched to the oldest request.
  always @(negedge clk) begin
    if (vote_accept || vote_reject) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_response", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("vote_accept", int'(vote_accept), int'(e.acc));
        chk("vote_reject", int'(vote_reject), int'(!e.acc));
        chk("reject_code", int'(reject_code), e.code);
      end
    end else if (reject_code != 2'd0) begin
      chk("idle_reject_code", int'(reject_code), 0);
    end
  end

  initial begin
    reset = 1; open_poll = 0; close_poll = 0; vote_valid = 0;
    voter_id = '0; cand_sel = '0;
    clear_session();
    st_m = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Basic session: c1=2, c3=1, winner 1.
    step(0, 1, 0, 0, 0, 0);
    vote(0, 1); vote(1, 1); vote(2, 3);
    step(0, 0, 1, 0, 0, 0);
    idle(NC + 1);

    // Duplicate voter back to back.
    step(0, 1, 0, 0, 0, 0);
    vote(5, 0); vote(5, 2);
    // Bad candidate, then closed-poll votes in DONE and IDLE.
    vote(6, 5); vote(7, 7);
    step(0, 0, 1, 0, 0, 0);
    idle(NC);
    vote(8, 1);
    step(1, 0, 0, 0, 0, 0);
    vote(9, 1);

    // Saturation: four voters on a 2-bit counter.
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) vote(i, 0);
    vote(10, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(NC);

    // Two-way tie, then empty poll.
    step(0, 1, 0, 0, 0, 0);
    vote(0, 0); vote(1, 2);
    step(0, 0, 1, 0, 0, 0);
    idle(NC);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(NC);

    // Vote on the closing edge, reset mid-tally.
    step(0, 1, 0, 0, 0, 0);
    vote(3, 4);
    step(0, 0, 1, 1, 4, 4);
    idle(2);
    step(1, 0, 0, 0, 0, 0);
    idle(2);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bit rs, op, cl, vv;
      rs = ($urandom_range(0, 199) == 0);
      op = ($urandom_range(0, 19) == 0);
      cl = ($urandom_range(0, 29) == 0);
      vv = ($urandom_range(0, 9) < 7);
      step(rs, op, cl, vv, $urandom_range(0, NV - 1),
           $urandom_range(0, (1 << CAW) - 1));
    end
    idle(2);
    @(negedge clk);
    #1;
    chk("responses_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
